// File: rtl/bus_region_router_if.sv
// Bus bundle between the CPU data port, the region router and the peripherals.
// The slave modport is the router's view; master is the CPU/peripheral side.
interface bus_region_router_if #(
    parameter int N_REGIONS = 9
);
    logic                      i_req;
    logic [31:0]               i_addr;
    logic                      i_we;
    logic [31:0]               i_wdata;
    logic                      o_done;
    logic                      o_err;
    logic [31:0]               o_rdata;
    logic [N_REGIONS-1:0]      o_sel;
    logic [31:0]               o_addr;
    logic                      o_we;
    logic [31:0]               o_wdata;
    logic [N_REGIONS-1:0]      i_slave_done;
    logic [32*N_REGIONS-1:0]   i_slave_rdata;

    modport slave (
        input  i_req, i_addr, i_we, i_wdata, i_slave_done, i_slave_rdata,
        output o_done, o_err, o_rdata, o_sel, o_addr, o_we, o_wdata
    );

    modport master (
        output i_req, i_addr, i_we, i_wdata, i_slave_done, i_slave_rdata,
        input  o_done, o_err, o_rdata, o_sel, o_addr, o_we, o_wdata
    );
endinterface

// File: rtl/bus_region_router.sv
// Registered base/mask address decoder and single-outstanding-transaction router.
// Define BUS_TIMEOUT_EN to add an ACCESS-state watchdog that errors out hung slaves.
module bus_region_router #(
    parameter int                      N_REGIONS      = 9,
    parameter logic [32*N_REGIONS-1:0] REGION_BASE    = {N_REGIONS{32'h0}},
    parameter logic [32*N_REGIONS-1:0] REGION_MASK    = {N_REGIONS{32'hF000_0000}},
    parameter logic [N_REGIONS-1:0]    REGION_EN      = {N_REGIONS{1'b1}},
    parameter int                      TIMEOUT_CYCLES = 255
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    bus_region_router_if.slave  bus
);

    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be in 1..65535");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [N_REGIONS-1:0] sel_q, sel_d;
    logic [31:0]          addr_q, addr_d;
    logic                 we_q, we_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [31:0]          rdata_q, rdata_d;

    logic [N_REGIONS-1:0] hit_sel;
    logic                 hit;
    logic                 sel_done;
    logic [31:0]          rdata_sel;

`ifdef BUS_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
`endif

    // Descending scan so the lowest matching index overwrites any higher one.
    always_comb begin
        hit_sel = '0;
        hit     = 1'b0;
        for (int k = N_REGIONS - 1; k >= 0; k--) begin
            if (REGION_EN[k] &&
                ((bus.i_addr & REGION_MASK[32*k +: 32]) ==
                 (REGION_BASE[32*k +: 32] & REGION_MASK[32*k +: 32]))) begin
                hit_sel    = '0;
                hit_sel[k] = 1'b1;
                hit        = 1'b1;
            end
        end
    end

    // sel_q is one-hot, so an OR of the gated slices is the read-data mux.
    always_comb begin
        rdata_sel = '0;
        for (int k = 0; k < N_REGIONS; k++) begin
            if (sel_q[k]) rdata_sel = rdata_sel | bus.i_slave_rdata[32*k +: 32];
        end
    end

    assign sel_done = |(bus.i_slave_done & sel_q);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
`ifdef BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.i_req) begin
                    if (hit) begin
                        state_d = S_ACCESS;
                        sel_d   = hit_sel;
                        addr_d  = bus.i_addr;
                        we_d    = bus.i_we;
                        wdata_d = bus.i_wdata;
`ifdef BUS_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = S_RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                // A selected done wins over a watchdog expiry in the same cycle.
                if (sel_done) begin
                    state_d = S_RESP;
                    sel_d   = '0;
                    done_d  = 1'b1;
                    rdata_d = we_q ? 32'h0 : rdata_sel;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt_q == TO_LIM) begin
                    state_d = S_RESP;
                    sel_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.o_sel   = sel_q;
    assign bus.o_addr  = addr_q;
    assign bus.o_we    = we_q;
    assign bus.o_wdata = wdata_q;
    assign bus.o_done  = done_q;
    assign bus.o_err   = err_q;
    assign bus.o_rdata = rdata_q;

endmodule

// File: tb/tb_bus_region_router.sv
// Bench for bus_region_router: directed scenarios plus randomized transactions
// checked against an address-range model of the region map.
module tb_bus_region_router;

    localparam int N = 9;

    // Region 0: 8 kB at 0; 1..4, 6, 7: one 256 MB nibble each; 5 overlaps 0x2/0x3; 8 disabled.
    localparam logic [32*N-1:0] P_BASE = {32'h8000_0000, 32'h7000_0000, 32'h6000_0000,
                                          32'h2000_0000, 32'h4000_0000, 32'h3000_0000,
                                          32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [32*N-1:0] P_MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000,
                                          32'hE000_0000, 32'hF000_0000, 32'hF000_0000,
                                          32'hF000_0000, 32'hF000_0000, 32'hFFFF_E000};
    localparam logic [N-1:0]    P_EN   = 9'b0_1111_1111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference map as inclusive address ranges, scanned in priority order.
    logic [31:0] lo_t [N] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000,
                              32'h4000_0000, 32'h2000_0000, 32'h6000_0000, 32'h7000_0000,
                              32'h8000_0000};
    logic [31:0] hi_t [N] = '{32'h0000_1FFF, 32'h1FFF_FFFF, 32'h2FFF_FFFF, 32'h3FFF_FFFF,
                              32'h4FFF_FFFF, 32'h3FFF_FFFF, 32'h6FFF_FFFF, 32'h7FFF_FFFF,
                              32'h8FFF_FFFF};
    bit          en_t [N] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};

    bus_region_router_if #(.N_REGIONS(N)) bus ();

    bus_region_router #(
        .N_REGIONS      (N),
        .REGION_BASE    (P_BASE),
        .REGION_MASK    (P_MASK),
        .REGION_EN      (P_EN),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic int ref_region(input logic [31:0] a);
        for (int k = 0; k < N; k++) begin
            if (en_t[k] && a >= lo_t[k] && a <= hi_t[k]) return k;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rdata();
        for (int k = 0; k < N; k++) bus.i_slave_rdata[32*k +: 32] = $urandom();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},   32'(bus.o_sel),   32'h0);
        check({tag, "_done"},  32'(bus.o_done),  32'h0);
        check({tag, "_err"},   32'(bus.o_err),   32'h0);
        check({tag, "_rdata"}, bus.o_rdata,      32'h0);
        check({tag, "_addr"},  bus.o_addr,       32'h0);
        check({tag, "_we"},    32'(bus.o_we),    32'h0);
        check({tag, "_wdata"}, bus.o_wdata,      32'h0);
    endtask

    // One complete transaction; slave answers after dly wait cycles.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input int dly, input logic repulse, input logic [N-1:0] spur);
        int          idx;
        logic [N-1:0] exp_sel;
        logic [31:0] exp_rd;
        idx = ref_region(addr);
        bus.i_req        = 1'b1;
        bus.i_addr       = addr;
        bus.i_we         = we;
        bus.i_wdata      = wdata;
        bus.i_slave_done = '0;
        tick();
        bus.i_req   = 1'b0;
        bus.i_addr  = $urandom();
        bus.i_we    = ~we;
        bus.i_wdata = $urandom();
        if (idx < 0) begin
            check("unmap_done",  32'(bus.o_done), 32'h1);
            check("unmap_err",   32'(bus.o_err),  32'h1);
            check("unmap_rdata", bus.o_rdata,     32'h0);
            check("unmap_sel",   32'(bus.o_sel),  32'h0);
            tick();
            check("unmap_pulse", 32'(bus.o_done), 32'h0);
            check("unmap_sel2",  32'(bus.o_sel),  32'h0);
            return;
        end
        exp_sel = N'(1) << idx;
        check("acc_sel",   32'(bus.o_sel),  32'(exp_sel));
        check("acc_done",  32'(bus.o_done), 32'h0);
        check("acc_addr",  bus.o_addr,      addr);
        check("acc_we",    32'(bus.o_we),   32'(we));
        check("acc_wdata", bus.o_wdata,     wdata);
        for (int c = 0; c < dly; c++) begin
            bus.i_req        = repulse;
            bus.i_slave_done = spur & ~exp_sel;
            fill_rdata();
            tick();
            check("wait_sel",   32'(bus.o_sel),  32'(exp_sel));
            check("wait_done",  32'(bus.o_done), 32'h0);
            check("wait_we",    32'(bus.o_we),   32'(we));
            check("wait_wdata", bus.o_wdata,     wdata);
        end
        bus.i_req = 1'b0;
        fill_rdata();
        bus.i_slave_done = exp_sel | (spur & ~exp_sel);
        exp_rd = we ? 32'h0 : bus.i_slave_rdata[32*idx +: 32];
        tick();
        bus.i_slave_done = '0;
        check("resp_done",  32'(bus.o_done), 32'h1);
        check("resp_err",   32'(bus.o_err),  32'h0);
        check("resp_rdata", bus.o_rdata,     exp_rd);
        check("resp_sel",   32'(bus.o_sel),  32'h0);
        tick();
        check("post_done", 32'(bus.o_done), 32'h0);
        check("post_sel",  32'(bus.o_sel),  32'h0);
    endtask

    initial begin
        logic [31:0] a;
        bus.i_req         = 1'b0;
        bus.i_addr        = '0;
        bus.i_we          = 1'b0;
        bus.i_wdata       = '0;
        bus.i_slave_done  = '0;
        bus.i_slave_rdata = '0;
        rst_n = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic read, slave answers in the first ACCESS cycle.
        run_txn(32'h1000_0040, 1'b0, 32'h0, 0, 1'b0, '0);
        // Unmapped: disabled region, beyond 8 kB boot region, gap, top nibble.
        run_txn(32'h9000_0000, 1'b0, 32'h0, 0, 1'b0, '0);
        run_txn(32'h8000_0000, 1'b0, 32'h0, 0, 1'b0, '0);
        run_txn(32'h0000_2000, 1'b1, 32'h1234, 0, 1'b0, '0);
        run_txn(32'h5000_0000, 1'b0, 32'h0, 0, 1'b0, '0);
        run_txn(32'h0000_1FFC, 1'b0, 32'h0, 2, 1'b0, '0);
        // Overlap: region 2 wins over 5; a done on bit 5 must be ignored.
        run_txn(32'h2000_0000, 1'b0, 32'h0, 3, 1'b0, 9'b0_0010_0000);
        run_txn(32'h3000_0010, 1'b0, 32'h0, 2, 1'b0, 9'b0_0010_0000);
        // Write with request re-pulsed during ACCESS.
        run_txn(32'h4000_0004, 1'b1, 32'h0000_0055, 3, 1'b1, '0);

`ifdef BUS_TIMEOUT_EN
        begin
            int hi_cnt;
            int w;
            hi_cnt = 0;
            w      = 0;
            bus.i_req   = 1'b1;
            bus.i_addr  = 32'h1000_0000;
            bus.i_we    = 1'b0;
            tick();
            bus.i_req = 1'b0;
            while (bus.o_done !== 1'b1 && w < 30) begin
                if (bus.o_sel != '0) hi_cnt++;
                tick();
                w++;
            end
            check("to_done",   32'(bus.o_done), 32'h1);
            check("to_err",    32'(bus.o_err),  32'h1);
            check("to_rdata",  bus.o_rdata,     32'h0);
            check("to_cycles", 32'(hi_cnt),     32'd10);
            tick();
        end
`endif

        // Reset mid-ACCESS aborts with no completion pulse.
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h4000_0004;
        bus.i_we   = 1'b1;
        bus.i_wdata = 32'hDEAD_BEEF;
        tick();
        bus.i_req = 1'b0;
        check("rst_pre_sel", 32'(bus.o_sel), 32'h10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_all_zero("rst_mid");
        tick();
        check("rst_no_done", 32'(bus.o_done), 32'h0);
        check("rst_no_sel",  32'(bus.o_sel),  32'h0);
        run_txn(32'h6000_0100, 1'b0, 32'h0, 1, 1'b0, '0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            a = $urandom();
            if (a[31:28] == 4'h0 && $urandom_range(0, 1) == 1) a[27:14] = '0;
            run_txn(a, 1'($urandom_range(0, 1)), $urandom(), int'($urandom_range(0, 5)),
                    1'($urandom_range(0, 1)), N'($urandom()));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
